// File: rtl/sisc_ctrl_mc_pkg.sv
// Shared definitions for the SISC multi-cycle control unit: FSM states,
// opcode numbers, instruction classes and alu_op codes.
package sisc_ctrl_mc_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_WB2     = 3'd6,
        ST_HALT    = 3'd7
    } state_t;

    // Instruction classes after opcode decode; HLT is the all-ones opcode.
    typedef enum logic [3:0] {
        I_NOOP, I_LOD, I_STR, I_SWP, I_BRA, I_BRR, I_BNE, I_BNR, I_ALU, I_HLT, I_ILL
    } inst_t;

    localparam int OPC_NOOP = 0;
    localparam int OPC_LOD  = 1;
    localparam int OPC_STR  = 2;
    localparam int OPC_SWP  = 3;
    localparam int OPC_BRA  = 4;
    localparam int OPC_BRR  = 5;
    localparam int OPC_BNE  = 6;
    localparam int OPC_BNR  = 7;
    localparam int OPC_ALU  = 8;

    localparam logic [1:0] ALU_REG_REG  = 2'b00;
    localparam logic [1:0] ALU_REG_IMM  = 2'b01;
    localparam logic [1:0] ALU_ADDR_REG = 2'b10;
    localparam logic [1:0] ALU_ADDR_IMM = 2'b11;

    // ALU instructions use the data modes, memory instructions the address modes.
    function automatic logic [1:0] alu_mode(input logic is_alu, input logic is_imm);
        if (is_alu) return is_imm ? ALU_REG_IMM : ALU_REG_REG;
        return is_imm ? ALU_ADDR_IMM : ALU_ADDR_REG;
    endfunction

endpackage

// File: rtl/sisc_ctrl_mc_if.sv
// Control-unit boundary: IR/status fields and memory handshakes in, datapath
// controls out. slave = control unit, master = datapath / environment.
interface sisc_ctrl_mc_if #(
    parameter int OP_W     = 4,
    parameter int MM_W     = 4,
    parameter int ALU_OP_W = 2
);
    import sisc_ctrl_mc_pkg::*;

    logic [OP_W-1:0]     opcode;
    logic [MM_W-1:0]     mm;
    logic [MM_W-1:0]     stat;
    // Handshake: req rises and is held every cycle until ack is seen in the
    // same cycle (ack is a single-cycle completion strobe) or until timeout.
    logic                imem_req;
    logic                imem_ack;
    logic                dmem_req;
    logic                dmem_ack;
    logic                dmem_we;
    logic                pc_rst;
    logic                pc_write;
    logic                pc_sel;
    logic                br_sel;
    logic                ir_load;
    logic                rf_we;
    logic                rd_sel;
    logic                rb_sel;
    logic                wb_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                halted;
    logic                bus_err;
    logic                illegal;
    state_t              dbg_state;

    modport slave (
        input  opcode, mm, stat, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, pc_rst, pc_write, pc_sel, br_sel,
               ir_load, rf_we, rd_sel, rb_sel, wb_sel, alu_op, halted, bus_err,
               illegal, dbg_state
    );

    modport master (
        output opcode, mm, stat, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, pc_rst, pc_write, pc_sel, br_sel,
               ir_load, rf_we, rd_sel, rb_sel, wb_sel, alu_op, halted, bus_err,
               illegal, dbg_state
    );

endinterface

// File: rtl/sisc_ctrl_mc_wait_timer.sv
// Wait-state counter shared by FETCH and MEM; expired flags TMO_CYC waiting
// cycles. TMO_CYC = 0 means the timer never expires.
module sisc_ctrl_mc_wait_timer #(
    parameter int TMO_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (TMO_CYC != 0) && (cnt == CNT_W'(TMO_CYC));

endmodule

// File: rtl/sisc_ctrl_mc.sv
// SISC multi-cycle control unit: sequences PC, IR, register file, ALU and
// data memory, with wait-state handshakes, timeout and a HALT state.
module sisc_ctrl_mc
    import sisc_ctrl_mc_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int MM_W     = 4,
    parameter int ALU_OP_W = 2,
    parameter int TMO_CYC  = 16
) (
    input logic           clk,
    input logic           rst,
    sisc_ctrl_mc_if.slave bus
);
    localparam logic [OP_W-1:0] OP_HLT = '1;
    localparam logic [MM_W-1:0] AM_IMM = {1'b1, {(MM_W-1){1'b0}}};

    state_t              state;
    state_t              state_nxt;
    inst_t               inst;
    logic                cond;
    logic [ALU_OP_W-1:0] alu_code;
    logic                wait_st;
    logic                cur_ack;
    logic                tmr_clr;
    logic                tmr_expired;

    always_comb begin
        case (bus.opcode)
            OP_W'(OPC_NOOP): inst = I_NOOP;
            OP_W'(OPC_LOD):  inst = I_LOD;
            OP_W'(OPC_STR):  inst = I_STR;
            OP_W'(OPC_SWP):  inst = I_SWP;
            OP_W'(OPC_BRA):  inst = I_BRA;
            OP_W'(OPC_BRR):  inst = I_BRR;
            OP_W'(OPC_BNE):  inst = I_BNE;
            OP_W'(OPC_BNR):  inst = I_BNR;
            OP_W'(OPC_ALU):  inst = I_ALU;
            OP_HLT:          inst = I_HLT;
            default:         inst = I_ILL;
        endcase
    end

    assign cond     = |(bus.stat & bus.mm);
    assign alu_code = ALU_OP_W'(alu_mode(inst == I_ALU, bus.mm == AM_IMM));

    // The counter runs only while a request is outstanding; any ack, timeout
    // or move to another state returns it to zero for the next wait.
    assign wait_st = (state == ST_FETCH) || (state == ST_MEM);
    assign cur_ack = (state == ST_FETCH) ? bus.imem_ack : bus.dmem_ack;
    assign tmr_clr = !wait_st || cur_ack || tmr_expired;

    sisc_ctrl_mc_wait_timer #(.TMO_CYC(TMO_CYC)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (wait_st),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    assign bus.dbg_state = state;

    always_comb begin
        state_nxt    = state;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.pc_rst   = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.br_sel   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.rd_sel   = 1'b0;
        bus.rb_sel   = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.alu_op   = '0;
        bus.halted   = 1'b0;
        bus.bus_err  = 1'b0;
        bus.illegal  = 1'b0;

        case (state)
            ST_RESET: begin
                bus.pc_rst = 1'b1;
                state_nxt  = ST_FETCH;
            end

            ST_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    bus.ir_load  = 1'b1;
                    bus.pc_write = 1'b1;
                    state_nxt    = ST_DECODE;
                end else if (tmr_expired) begin
                    bus.imem_req = 1'b0;
                    bus.bus_err  = 1'b1;
                    state_nxt    = ST_FETCH;
                end
            end

            ST_DECODE: begin
                state_nxt = ST_FETCH;
                case (inst)
                    I_BRA, I_BRR: begin
                        bus.pc_write = cond;
                        bus.pc_sel   = cond;
                        bus.br_sel   = cond && (inst == I_BRA);
                    end
                    I_BNE, I_BNR: begin
                        bus.pc_write = !cond;
                        bus.pc_sel   = !cond;
                        bus.br_sel   = !cond && (inst == I_BNE);
                    end
                    I_ALU, I_LOD, I_STR, I_SWP: state_nxt = ST_EXECUTE;
                    I_HLT:                      state_nxt = ST_HALT;
                    I_ILL:                      bus.illegal = 1'b1;
                    default:                    state_nxt = ST_FETCH;
                endcase
            end

            ST_EXECUTE: begin
                bus.alu_op = alu_code;
                bus.rb_sel = (inst == I_STR) || (inst == I_SWP);
                if ((inst == I_LOD) || (inst == I_STR)) begin
                    state_nxt = ST_MEM;
                end else if ((inst == I_ALU) || (inst == I_SWP)) begin
                    state_nxt = ST_WB;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end

            ST_MEM: begin
                bus.alu_op   = alu_code;
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (inst == I_STR);
                if (bus.dmem_ack) begin
                    state_nxt = (inst == I_LOD) ? ST_WB : ST_FETCH;
                end else if (tmr_expired) begin
                    bus.dmem_req = 1'b0;
                    bus.dmem_we  = 1'b0;
                    bus.bus_err  = 1'b1;
                    state_nxt    = ST_FETCH;
                end
            end

            ST_WB: begin
                bus.rf_we  = 1'b1;
                bus.wb_sel = (inst == I_LOD);
                state_nxt  = (inst == I_SWP) ? ST_WB2 : ST_FETCH;
            end

            ST_WB2: begin
                bus.rf_we  = 1'b1;
                bus.rd_sel = 1'b1;
                state_nxt  = ST_FETCH;
            end

            ST_HALT: begin
                bus.halted = 1'b1;
            end

            default: state_nxt = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Bench for sisc_ctrl_mc: an instruction-level model expands each issued
// instruction into expected per-cycle control words; a monitor checks them.
module tb_sisc_ctrl_mc;
    import sisc_ctrl_mc_pkg::*;

    localparam int OP_W = 4;
    localparam int MM_W = 4;
    localparam int ALU_OP_W = 2;
    localparam int TMO = 16;
    localparam int W = 17;

    localparam int B_IREQ = 16, B_DREQ = 15, B_DWE = 14, B_PCRST = 13;
    localparam int B_PCW = 12, B_PCSEL = 11, B_BRSEL = 10, B_IRLD = 9;
    localparam int B_RFWE = 8, B_RDSEL = 7, B_RBSEL = 6, B_WBSEL = 5;
    localparam int B_ALU = 3, B_HALT = 2, B_BERR = 1, B_ILL = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sisc_ctrl_mc_if #(.OP_W(OP_W), .MM_W(MM_W), .ALU_OP_W(ALU_OP_W)) bus ();

    sisc_ctrl_mc #(
        .OP_W(OP_W), .MM_W(MM_W), .ALU_OP_W(ALU_OP_W), .TMO_CYC(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] obs_v;
    assign obs_v = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.pc_rst, bus.pc_write,
                    bus.pc_sel, bus.br_sel, bus.ir_load, bus.rf_we, bus.rd_sel, bus.rb_sel,
                    bus.wb_sel, bus.alu_op, bus.halted, bus.bus_err, bus.illegal};

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    bit           done = 1'b0;

    function automatic logic [W-1:0] bv(input int b);
        return W'(1) << b;
    endfunction

    function automatic logic [W-1:0] alu_v(input logic [1:0] a);
        return W'(a) << B_ALU;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic ia, input logic da, input logic [W-1:0] e, input string t);
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_phase(input int w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= TMO; i++) begin
            if (i == w) begin
                cyc(1'b1, 1'b0, bv(B_IREQ) | bv(B_IRLD) | bv(B_PCW), "fetch_ack");
                ok = 1'b1;
                return;
            end
            if (i == TMO) begin
                cyc(1'b0, 1'b0, bv(B_BERR), "fetch_timeout");
                return;
            end
            cyc(1'b0, 1'b0, bv(B_IREQ), "fetch_wait");
        end
    endtask

    // Reference model: one instruction from fetch to its last cycle.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st,
                             input int fw, input int mw);
        bit           ok;
        bit           cond;
        bit           taken;
        logic [1:0]   a;
        logic [W-1:0] e;
        logic [W-1:0] mreq;
        int           w;
        w = fw;
        fetch_phase(w, ok);
        while (!ok) begin
            w = $urandom_range(0, 2);
            fetch_phase(w, ok);
        end
        bus.opcode = op;
        bus.mm     = mm;
        bus.stat   = st;
        cond  = |(st & mm);
        taken = ((op == 4 || op == 5) && cond) || ((op == 6 || op == 7) && !cond);
        e = '0;
        if (taken) e = bv(B_PCW) | bv(B_PCSEL) | ((op == 4 || op == 6) ? bv(B_BRSEL) : '0);
        if (op >= 9 && op <= 14) e = bv(B_ILL);
        cyc(1'b0, 1'b0, e, "decode");
        if (!(op == 1 || op == 2 || op == 3 || op == 8)) return;

        a = {op != 8, mm == 4'b1000};
        cyc(1'b0, 1'b0, alu_v(a) | ((op == 2 || op == 3) ? bv(B_RBSEL) : '0), "execute");
        if (op == 1 || op == 2) begin
            mreq = bv(B_DREQ) | ((op == 2) ? bv(B_DWE) : '0) | alu_v(a);
            for (int i = 0; i <= TMO; i++) begin
                if (i == mw) begin
                    cyc(1'b0, 1'b1, mreq, "mem_ack");
                    break;
                end
                if (i == TMO) begin
                    cyc(1'b0, 1'b0, bv(B_BERR) | alu_v(a), "mem_timeout");
                    return;
                end
                cyc(1'b0, 1'b0, mreq, "mem_wait");
            end
            if (op == 2) return;
        end
        cyc(1'b0, 1'b0, bv(B_RFWE) | ((op == 1) ? bv(B_WBSEL) : '0), "wb");
        if (op == 3) cyc(1'b0, 1'b0, bv(B_RFWE) | bv(B_RDSEL), "wb2");
    endtask

    task automatic reset_seq(input logic [W-1:0] first_exp, input int n_high);
        rst = 1'b1;
        cyc(1'b0, 1'b0, first_exp, "rst_entry");
        for (int i = 1; i < n_high; i++) cyc(1'b0, 1'b0, bv(B_PCRST), "rst_hold");
        rst = 1'b0;
        cyc(1'b0, 1'b0, bv(B_PCRST), "rst_exit");
    endtask

    task automatic rst_mid_mem();
        bit ok;
        fetch_phase(0, ok);
        bus.opcode = 4'd1;
        bus.mm     = 4'd0;
        bus.stat   = 4'd0;
        cyc(1'b0, 1'b0, '0, "decode_lod");
        cyc(1'b0, 1'b0, alu_v(2'b10), "execute_lod");
        cyc(1'b0, 1'b0, bv(B_DREQ) | alu_v(2'b10), "mem_wait");
        cyc(1'b0, 1'b0, bv(B_DREQ) | alu_v(2'b10), "mem_wait");
        reset_seq(bv(B_DREQ) | alu_v(2'b10), 2);
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) return 0;
        if (r < 18) return $urandom_range(1, 4);
        if (r == 18) return TMO;
        return 40;
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stimulus
        rst          = 1'b1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.opcode   = '0;
        bus.mm       = '0;
        bus.stat     = '0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, bv(B_PCRST), "reset_hold");
        cyc(1'b0, 1'b0, bv(B_PCRST), "reset_hold");
        rst = 1'b0;
        cyc(1'b0, 1'b0, bv(B_PCRST), "reset_release");

        run_instr(4'd8, 4'b1000, 4'd0, 0, 0);        // ALU reg-imm
        run_instr(4'd8, 4'b0011, 4'd0, 1, 0);        // ALU reg-reg
        run_instr(4'd6, 4'b0001, 4'b0000, 0, 0);     // BNE taken
        run_instr(4'd6, 4'b0001, 4'b0001, 0, 0);     // BNE not taken
        run_instr(4'd4, 4'b0110, 4'b0100, 0, 0);     // BRA taken
        run_instr(4'd5, 4'b0110, 4'b0001, 0, 0);     // BRR not taken
        run_instr(4'd7, 4'b1000, 4'b0111, 0, 0);     // BNR taken
        run_instr(4'd1, 4'b0011, 4'd0, 0, 5);        // LOD, 5 wait cycles
        run_instr(4'd2, 4'b1000, 4'd0, 0, 99);       // STR, no ack -> timeout
        run_instr(4'd3, 4'b0010, 4'd0, 0, 0);        // SWP
        run_instr(4'd1, 4'b1000, 4'd0, TMO, TMO);    // ack on the timeout cycle
        run_instr(4'd0, 4'd0, 4'd0, 99, 0);          // fetch timeout then retry
        run_instr(4'd11, 4'd0, 4'd0, 0, 0);          // undefined opcode
        run_instr(4'd15, 4'd0, 4'd0, 0, 0);          // HLT
        cyc(1'b1, 1'b0, bv(B_HALT), "halted");
        cyc(1'b1, 1'b1, bv(B_HALT), "halted");
        cyc(1'b0, 1'b0, bv(B_HALT), "halted");
        reset_seq(bv(B_HALT), 2);
        run_instr(4'd8, 4'b0001, 4'd0, 0, 0);
        rst_mid_mem();
        run_instr(4'd2, 4'b0101, 4'd0, 2, 3);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] op;
            logic [3:0] mm;
            op = 4'($urandom_range(0, 14));
            mm = ($urandom_range(0, 3) == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
            run_instr(op, mm, 4'($urandom_range(0, 15)), pick_wait(), pick_wait());
        end

        @(posedge clk);
        #1;
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [W-1:0] e;
        string        t;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_checks++;
                if (obs_v !== e) begin
                    n_fail++;
                    $display("FAIL %s @%0t (state %s): got %b expected %b",
                             t, $time, bus.dbg_state.name(), obs_v, e);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected words left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck stimulus process.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
